// File: rtl/serial_collect8_ctrl_pkg.sv
// serial_collect8_ctrl_pkg
// Shared constants and types for the serial-to-parallel frame collector.
//   LANES      : samples per frame
//   DW         : width of one real or imaginary sample
//   FW         : width of one packed frame (LANES*DW)
//   outState_t : output-side state, EMPTY = no frame waiting, PEND = frame held for downstream
package serial_collect8_ctrl_pkg;

  localparam int LANES = 8;
  localparam int DW    = 10;
  localparam int FW    = LANES * DW;

  typedef enum logic {
    EMPTY = 1'b0,
    PEND  = 1'b1
  } outState_t;

endpackage

// File: rtl/serial_collect8_ctrl_if.sv
// serial_collect8_ctrl_if
// Bundles the serial input handshake and the packed-frame output of the collector.
//   din_valid/din_ready : serial sample handshake (sample taken when both high)
//   frame_sync          : with din_valid, marks the sample as lane 0 of a new frame
//   dinre/dinim         : signed serial sample
//   dout_ready/ren      : downstream idle indication and one-cycle load strobe
//   doutre/doutim       : packed frame, lane k at bits [10k+9:10k]
//   sync_err            : sticky mid-frame sync indication
// The slave modport is the collector; the master modport is its environment.
interface serial_collect8_ctrl_if;
  import serial_collect8_ctrl_pkg::*;

  logic          din_valid;
  logic          din_ready;
  logic          frame_sync;
  logic [DW-1:0] dinre;
  logic [DW-1:0] dinim;
  logic          dout_ready;
  logic          ren;
  logic [FW-1:0] doutre;
  logic [FW-1:0] doutim;
  logic          sync_err;

  modport master (
    output din_valid, frame_sync, dinre, dinim, dout_ready,
    input  din_ready, ren, doutre, doutim, sync_err
  );

  modport slave (
    input  din_valid, frame_sync, dinre, dinim, dout_ready,
    output din_ready, ren, doutre, doutim, sync_err
  );

endinterface

// File: rtl/serial_collect8_ctrl_collect_lane_reg.sv
// collect_lane_reg
// One lane of the collect register: a DW-wide real/imaginary pair with write enable.
//   clk, rst_n   : clock and asynchronous active-low clear
//   i_we         : load i_re/i_im on this edge
//   i_re, i_im   : sample to store
//   o_re, o_im   : stored sample
module collect_lane_reg #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [DW-1:0] i_re,
  input  logic [DW-1:0] i_im,
  output logic [DW-1:0] o_re,
  output logic [DW-1:0] o_im
);

  logic [DW-1:0] r_re;
  logic [DW-1:0] r_im;

  // Hold the lane value until the collector selects this lane for a new sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_re <= '0;
      r_im <= '0;
    end else if (i_we) begin
      r_re <= i_re;
      r_im <= i_im;
    end
  end

  assign o_re = r_re;
  assign o_im = r_im;

endmodule

// File: rtl/serial_collect8_ctrl.sv
// serial_collect8_ctrl
// Collects LANES serial complex samples into one packed frame and hands it to a
// downstream shift register through a hold register and a two-state output FSM.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_collect8_ctrl_if.slave (sample handshake, frame_sync,
//           dout_ready/ren load handshake, packed frame, sync_err)
module serial_collect8_ctrl #(
  parameter int LANES = serial_collect8_ctrl_pkg::LANES,
  parameter int DW    = serial_collect8_ctrl_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_collect8_ctrl_if.slave bus
);
  import serial_collect8_ctrl_pkg::*;

  localparam int            CW   = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]       r_count;
  outState_t           r_state;
  logic                r_ren;
  logic                r_syncErr;
  logic [LANES*DW-1:0] r_holdRe;
  logic [LANES*DW-1:0] r_holdIm;

  logic                w_ready;
  logic                w_accept;
  logic                w_complete;
  logic [LANES-1:0]    w_laneWe;
  logic [DW-1:0]       w_laneRe [LANES];
  logic [DW-1:0]       w_laneIm [LANES];
  logic [LANES*DW-1:0] w_frameRe;
  logic [LANES*DW-1:0] w_frameIm;

  // Only the last sample of a frame needs a free hold register, so the block
  // stalls just there while a previous frame is still pending.
  assign w_ready    = (r_count != LAST) || (r_state == EMPTY);
  assign w_accept   = bus.din_valid && w_ready;
  assign w_complete = w_accept && !bus.frame_sync && (r_count == LAST);

  // A sync sample always goes to lane 0; otherwise the count picks the lane.
  // The frame image substitutes the incoming sample for the lane being written,
  // so on the last sample it is the complete frame ready for the hold register.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_laneWe[k] = w_accept && (bus.frame_sync ? (k == 0) : (r_count == CW'(k)));

    collect_lane_reg #(.DW(DW)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .i_we (w_laneWe[k]),
      .i_re (bus.dinre),
      .i_im (bus.dinim),
      .o_re (w_laneRe[k]),
      .o_im (w_laneIm[k])
    );

    assign w_frameRe[k*DW +: DW] = (r_count == CW'(k)) ? bus.dinre : w_laneRe[k];
    assign w_frameIm[k*DW +: DW] = (r_count == CW'(k)) ? bus.dinim : w_laneIm[k];
  end

  // Lane counter and sticky sync error. A sync sample restarts the frame with
  // itself in lane 0, dropping whatever partial frame was being built; LANES is
  // a power of two so the increment wraps naturally after the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_syncErr <= 1'b0;
    end else if (w_accept) begin
      if (bus.frame_sync) begin
        r_count <= CW'(1);
        if (r_count != '0) begin
          r_syncErr <= 1'b1;
        end
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // Output FSM. A completed frame is captured into the hold register and waits
  // in PEND until downstream is idle; the release edge raises ren for exactly
  // one cycle. The hold register may be reloaded on the edge that ends the ren
  // cycle because downstream samples the old value on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_ren    <= 1'b0;
      r_holdRe <= '0;
      r_holdIm <= '0;
    end else begin
      r_ren <= 1'b0;
      case (r_state)
        EMPTY: begin
          if (w_complete) begin
            r_state  <= PEND;
            r_holdRe <= w_frameRe;
            r_holdIm <= w_frameIm;
          end
        end
        PEND: begin
          if (bus.dout_ready) begin
            r_state <= EMPTY;
            r_ren   <= 1'b1;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign bus.din_ready = w_ready;
  assign bus.ren       = r_ren;
  assign bus.doutre    = r_holdRe;
  assign bus.doutim    = r_holdIm;
  assign bus.sync_err  = r_syncErr;

endmodule
